// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encoding and status layout.
package alu_pkg;

    localparam int STATUS_W       = 4;
    localparam int STATUS_OVF_BIT = 3;

    localparam logic [1:0] ST_LOAD_A = 2'd0;
    localparam logic [1:0] ST_LOAD_B = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    typedef enum logic [1:0] {
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_EXEC   = ST_EXEC,
        S_OUT    = ST_OUT
    } alu_seq_state_t;

endpackage

// File: rtl/alu_out_reg.sv
// Result/status holding register: loads on capture, holds until accepted or aborted.
module alu_out_reg
    import alu_pkg::*;
#(
    parameter int m = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture,
    input  logic                accept,
    input  logic                abort,
    input  logic [m-1:0]        op_res,
    input  logic [STATUS_W-1:0] op_status,
    output logic [m-1:0]        result,
    output logic [STATUS_W-1:0] status,
    output logic                valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            status <= '0;
            valid  <= 1'b0;
        end else begin
            // Abort and accept only drop valid; the captured data stays visible.
            if (abort || accept) begin
                valid <= 1'b0;
            end else if (capture) begin
                valid <= 1'b1;
            end
            if (capture) begin
                result <= op_res;
                status <= op_status;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer around the combinational ALU operators: loads A then B, runs one EXEC
// cycle, holds the result for the consumer and counts completed operations.
// Optional sticky overflow flag is built when ALU_STICKY_OVF_EN is defined.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int m = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [m-1:0]        i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_abort,
    output logic [m-1:0]        o_arg_A,
    output logic [m-1:0]        o_arg_B,
    input  logic [m-1:0]        i_res,
    input  logic [STATUS_W-1:0] i_status,
    output logic [m-1:0]        o_result,
    output logic [STATUS_W-1:0] o_status,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [m-1:0]        o_op_count,
    output logic                o_sticky_ovf
);

    alu_seq_state_t state;
    logic           capture;
    logic           accept;

    assign o_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign capture = (state == S_EXEC) && !i_abort;
    assign accept  = (state == S_OUT) && i_ready && !i_abort;

    // Abort outranks every handshake, so a word offered alongside it is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_LOAD_A;
            o_arg_A    <= '0;
            o_arg_B    <= '0;
            o_op_count <= '0;
        end else if (i_abort) begin
            state <= S_LOAD_A;
        end else begin
            case (state)
                S_LOAD_A: begin
                    if (i_valid) begin
                        o_arg_A <= i_data;
                        state   <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (i_valid) begin
                        o_arg_B <= i_data;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_op_count <= o_op_count + 1'b1;
                        state      <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_LOAD_A;
                end
            endcase
        end
    end

    alu_out_reg #(
        .m(m)
    ) u_out_reg (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .capture  (capture),
        .accept   (accept),
        .abort    (i_abort),
        .op_res   (i_res),
        .op_status(i_status),
        .result   (o_result),
        .status   (o_status),
        .valid    (o_valid)
    );

`ifdef ALU_STICKY_OVF_EN
    logic sticky_ovf;

    // Clear beats set when abort lands on the capture edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (i_abort) begin
            sticky_ovf <= 1'b0;
        end else if (capture && i_status[STATUS_OVF_BIT]) begin
            sticky_ovf <= 1'b1;
        end
    end

    assign o_sticky_ovf = sticky_ovf;
`else
    assign o_sticky_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer (m = 8) with a comparison-unit operator model.
module tb_alu_operand_sequencer;

    import alu_pkg::*;

`ifdef ALU_STICKY_OVF_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid_in;
    logic       ready_out;
    logic       abort;
    logic [7:0] arg_a;
    logic [7:0] arg_b;
    logic [7:0] res;
    logic [3:0] status_in;
    logic [7:0] result;
    logic [3:0] status_out;
    logic       valid_out;
    logic       ready_in;
    logic [7:0] op_count;
    logic       sticky;

    logic       op_mode;
    logic [7:0] res_frc;
    logic [3:0] st_frc;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.m(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (data),
        .i_valid     (valid_in),
        .o_ready     (ready_out),
        .i_abort     (abort),
        .o_arg_A     (arg_a),
        .o_arg_B     (arg_b),
        .i_res       (res),
        .i_status    (status_in),
        .o_result    (result),
        .o_status    (status_out),
        .o_valid     (valid_out),
        .i_ready     (ready_in),
        .o_op_count  (op_count),
        .o_sticky_ovf(sticky)
    );

    // Signed comparison unit: result = (A > B), status bit 3 = overflow of A - B.
    function automatic logic [11:0] cmp_op(input logic [7:0] a, input logic [7:0] b);
        int  sa;
        int  sb;
        int  d;
        logic [7:0] r;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        d   = sa - sb;
        r   = (sa > sb) ? 8'h01 : 8'h00;
        ovf = (d > 127) || (d < -128);
        return {r, ovf, 3'b000};
    endfunction

    assign {res, status_in} = op_mode ? cmp_op(arg_a, arg_b) : {res_frc, st_frc};

    // Reference model: how many operand words are held and whether a result is pending.
    int         words;
    bit         in_exec;
    logic [7:0] ma, mb, mres, mcnt;
    logic [3:0] mst;
    logic       mvalid, msticky;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic [3:0] exp_st;
        logic [7:0] exp_cnt;
        bit         exp_stk;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        words   = 0;
        in_exec = 1'b0;
        ma      = 8'h00;
        mb      = 8'h00;
        mres    = 8'h00;
        mst     = 4'h0;
        mcnt    = 8'h00;
        mvalid  = 1'b0;
        msticky = 1'b0;
    endtask

    task automatic cycle();
        logic       pv, pa, pr;
        logic [7:0] pd, pres;
        logic [3:0] pst;
        #1;
        pv = valid_in; pa = abort; pr = ready_in; pd = data; pres = res; pst = status_in;
        @(posedge clk);
        if (pa) begin
            words   = 0;
            in_exec = 1'b0;
            mvalid  = 1'b0;
            msticky = 1'b0;
        end else if (mvalid) begin
            if (pr) begin
                mvalid = 1'b0;
                mcnt   = mcnt + 8'd1;
            end
        end else if (in_exec) begin
            in_exec = 1'b0;
            mres    = pres;
            mst     = pst;
            mvalid  = 1'b1;
            msticky = msticky | pst[3];
        end else if (pv) begin
            if (words == 0) begin
                ma    = pd;
                words = 1;
            end else begin
                mb      = pd;
                words   = 0;
                in_exec = 1'b1;
            end
        end
        #1;
    endtask

    task automatic check_model();
        chk("rnd ready",  32'(ready_out),  32'(!in_exec && !mvalid));
        chk("rnd arg_a",  32'(arg_a),      32'(ma));
        chk("rnd arg_b",  32'(arg_b),      32'(mb));
        chk("rnd valid",  32'(valid_out),  32'(mvalid));
        chk("rnd result", 32'(result),     32'(mres));
        chk("rnd status", 32'(status_out), 32'(mst));
        chk("rnd count",  32'(op_count),   32'(mcnt));
        chk("rnd sticky", 32'(sticky),     32'(STICKY_EN & msticky));
    endtask

    task automatic run_op(input vec_t v, input string tag);
        valid_in = 1'b1;
        data     = v.a;
        cycle();
        data = v.b;
        cycle();
        valid_in = 1'b0;
        chk({tag, " exec valid"}, 32'(valid_out), 0);
        cycle();
        chk({tag, " valid"},  32'(valid_out),  1);
        chk({tag, " result"}, 32'(result),     32'(v.exp_res));
        chk({tag, " status"}, 32'(status_out), 32'(v.exp_st));
        chk({tag, " ready"},  32'(ready_out),  0);
        chk({tag, " sticky"}, 32'(sticky),     32'(STICKY_EN & v.exp_stk));
        ready_in = 1'b1;
        cycle();
        ready_in = 1'b0;
        chk({tag, " drop valid"}, 32'(valid_out), 0);
        chk({tag, " count"},      32'(op_count),  32'(v.exp_cnt));
        chk({tag, " ready back"}, 32'(ready_out), 1);
    endtask

    task automatic quick_op(input logic [7:0] a, input logic [7:0] b);
        valid_in = 1'b1;
        data     = a;
        cycle();
        data = b;
        cycle();
        valid_in = 1'b0;
        cycle();
        ready_in = 1'b1;
        cycle();
        ready_in = 1'b0;
    endtask

    initial begin
        logic [7:0] cnt_save;
        vec_t       v;

        tbl[0] = '{a: 8'h05, b: 8'h03, exp_res: 8'h01, exp_st: 4'b0000, exp_cnt: 8'd1, exp_stk: 1'b0};
        tbl[1] = '{a: 8'h7F, b: 8'h80, exp_res: 8'h01, exp_st: 4'b1000, exp_cnt: 8'd2, exp_stk: 1'b1};
        tbl[2] = '{a: 8'h03, b: 8'h05, exp_res: 8'h00, exp_st: 4'b0000, exp_cnt: 8'd3, exp_stk: 1'b1};
        tbl[3] = '{a: 8'h80, b: 8'h7F, exp_res: 8'h00, exp_st: 4'b1000, exp_cnt: 8'd4, exp_stk: 1'b1};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, exp_res: 8'h00, exp_st: 4'b0000, exp_cnt: 8'd5, exp_stk: 1'b1};

        rst_n    = 1'b0;
        valid_in = 1'b1;
        data     = 8'hAA;
        abort    = 1'b0;
        ready_in = 1'b1;
        op_mode  = 1'b1;
        res_frc  = 8'h00;
        st_frc   = 4'h0;
        model_reset();

        // Reset state, with upstream offering words that must be ignored.
        #1;
        chk("reset ready",  32'(ready_out),  1);
        chk("reset valid",  32'(valid_out),  0);
        chk("reset result", 32'(result),     0);
        chk("reset status", 32'(status_out), 0);
        chk("reset count",  32'(op_count),   0);
        chk("reset sticky", 32'(sticky),     0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset arg_a", 32'(arg_a), 0);
        valid_in = 1'b0;
        ready_in = 1'b0;
        rst_n    = 1'b1;
        chk("post reset ready", 32'(ready_out), 1);

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i], $sformatf("op%0d", i));
        end

        // Backpressure: result must hold while the operator output churns.
        valid_in = 1'b1;
        data     = 8'h40;
        cycle();
        data = 8'h10;
        cycle();
        cycle();
        op_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res_frc  = 8'($urandom);
            st_frc   = 4'($urandom);
            data     = 8'($urandom);
            valid_in = 1'b1;
            cycle();
            chk("bp result", 32'(result),    32'h01);
            chk("bp ready",  32'(ready_out), 0);
            chk("bp valid",  32'(valid_out), 1);
            chk("bp arg_a",  32'(arg_a),     32'h40);
            chk("bp arg_b",  32'(arg_b),     32'h10);
        end
        valid_in = 1'b0;
        op_mode  = 1'b1;
        ready_in = 1'b1;
        cycle();
        ready_in = 1'b0;
        chk("bp count", 32'(op_count), 6);

        // Abort in S_LOAD_B with a word on offer.
        cnt_save = op_count;
        valid_in = 1'b1;
        data     = 8'h33;
        cycle();
        data  = 8'h99;
        abort = 1'b1;
        cycle();
        abort    = 1'b0;
        valid_in = 1'b0;
        chk("abort ready",  32'(ready_out), 1);
        chk("abort arg_b",  32'(arg_b),     32'h10);
        chk("abort arg_a",  32'(arg_a),     32'h33);
        chk("abort count",  32'(op_count),  32'(cnt_save));
        chk("abort valid",  32'(valid_out), 0);
        chk("abort sticky", 32'(sticky),    0);
        valid_in = 1'b1;
        data     = 8'h44;
        cycle();
        valid_in = 1'b0;
        chk("abort reload A", 32'(arg_a), 32'h44);
        chk("abort keep B",   32'(arg_b), 32'h10);
        abort = 1'b1;
        cycle();
        abort = 1'b0;

        // Randomised traffic against the model.
        op_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data     = 8'($urandom);
            abort    = ($urandom_range(0, 15) == 0);
            ready_in = 1'($urandom_range(0, 1));
            res_frc  = 8'($urandom);
            st_frc   = 4'($urandom);
            cycle();
            check_model();
        end
        valid_in = 1'b0;
        ready_in = 1'b0;
        abort    = 1'b1;
        cycle();
        abort   = 1'b0;
        op_mode = 1'b1;
        check_model();

        // Counter wrap.
        for (int i = 0; i < 300 && mcnt != 8'hFF; i++) begin
            quick_op(8'(i), 8'(i + 3));
        end
        chk("wrap pre", 32'(op_count), 32'hFF);
        quick_op(8'h01, 8'h02);
        chk("wrap post", 32'(op_count), 32'h00);

        // Asynchronous reset while a result is pending.
        valid_in = 1'b1;
        data     = 8'h20;
        cycle();
        data = 8'h10;
        cycle();
        valid_in = 1'b0;
        cycle();
        chk("rst pre valid", 32'(valid_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst valid",  32'(valid_out), 0);
        chk("rst result", 32'(result),    0);
        chk("rst count",  32'(op_count),  0);
        chk("rst arg_a",  32'(arg_a),     0);
        chk("rst ready",  32'(ready_out), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst release ready", 32'(ready_out), 1);
        v = tbl[0];
        run_op(v, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
